// File: rtl/riscv_pkg.sv
// Shared constants and the decode-queue entry layout for the fetch stage.
package riscv_pkg;

   localparam int          XLEN      = 32;
   localparam logic [31:0] RESET_PC  = 32'h8000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // One buffered instruction as presented to decode: {err, pc, instr} = 65 bits.
   typedef struct packed {
      logic            err;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with clear. Occupancy is tracked by an explicit
// counter so empty/full never depend on pointer comparison. The read port is
// the head entry, shown combinationally; storage resets to RESET_VAL so the
// head has a defined value straight out of reset.
module sync_fifo #(
   parameter int             WIDTH     = 32,
   parameter int             DEPTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clear,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   // Pointers wrap explicitly at DEPTH-1 so non-power-of-2 depths also work.
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
   endfunction

   assign rdata = mem[rd_ptr];

   // Storage, pointers and occupancy; clear empties the FIFO but keeps storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= next_ptr(wr_ptr);
         end
         if (pop) rd_ptr <= next_ptr(rd_ptr);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
      end
   end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: issues reads at current_PC, tracks the PC of each
// accepted request, and buffers returned words for decode in order.
//
// Handshakes: imem side transfers a request when imem_req && imem_gnt in the
// same cycle (req/addr stay stable until then unless flushed); responses come
// back in order on imem_rvalid. Decode side transfers the head entry when
// dec_valid && dec_ready; outputs hold while the head is not taken.
//
// A request is only issued when the decode queue is guaranteed a slot for its
// response (queued + outstanding < DEPTH), so responses are never dropped for
// lack of space. On flush, every response still in flight is counted into
// drop_cnt and discarded on arrival.
module instr_fetch_queue
   import riscv_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int MAX_OUTST = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] current_PC,
   input  logic            flush,
   output logic            pc_advance,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            imem_err,
   output logic            dec_valid,
   input  logic            dec_ready,
   output logic [XLEN-1:0] dec_instr,
   output logic [XLEN-1:0] dec_pc,
   output logic            dec_err
);

   localparam int QCW = $clog2(DEPTH+1);
   localparam int OCW = $clog2(MAX_OUTST+1);
   localparam int SW  = ((QCW > OCW) ? QCW : OCW) + 1;
   localparam fetch_entry_t ENTRY_RESET = '{err: 1'b0, pc: RESET_PC, instr: NOP_INSTR};

   logic [QCW-1:0]  q_cnt;
   logic [OCW-1:0]  trk_cnt;
   logic [OCW-1:0]  outst_cnt;
   logic [OCW-1:0]  drop_cnt;
   logic [XLEN-1:0] trk_pc;
   fetch_entry_t    q_wdata;
   fetch_entry_t    q_head;
   logic            credit_ok;
   logic            grant;
   logic            rsp;
   logic            q_push;
   logic            q_pop;

   assign credit_ok  = ((SW'(q_cnt) + SW'(outst_cnt)) < SW'(DEPTH)) &&
                       (outst_cnt < OCW'(MAX_OUTST));
   // Request is held low while in reset so nothing is issued before release.
   assign imem_req   = rst_n && !flush && credit_ok;
   assign imem_addr  = current_PC;
   assign grant      = imem_req && imem_gnt;
   assign pc_advance = grant;

   // A response only counts when something is actually outstanding; stray
   // rvalid right after reset is ignored.
   assign rsp    = imem_rvalid && (outst_cnt != '0) && (trk_cnt != '0);
   assign q_push = rsp && (drop_cnt == '0) && !flush;

   assign dec_valid = (q_cnt != '0) && !flush;
   assign q_pop     = dec_valid && dec_ready;

   assign q_wdata   = '{err: imem_err, pc: trk_pc, instr: imem_rdata};
   assign dec_instr = q_head.instr;
   assign dec_pc    = q_head.pc;
   assign dec_err   = q_head.err;

   // PC of every accepted request, popped as its response arrives (kept or dropped).
   sync_fifo #(
      .WIDTH     (XLEN),
      .DEPTH     (MAX_OUTST),
      .RESET_VAL ('0)
   ) u_trk_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (1'b0),
      .push  (grant),
      .pop   (rsp),
      .wdata (current_PC),
      .rdata (trk_pc),
      .count (trk_cnt)
   );

   // Decode queue; flush empties it at the end of the flush cycle.
   sync_fifo #(
      .WIDTH     ($bits(fetch_entry_t)),
      .DEPTH     (DEPTH),
      .RESET_VAL (ENTRY_RESET)
   ) u_dec_queue (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (flush),
      .push  (q_push),
      .pop   (q_pop),
      .wdata (q_wdata),
      .rdata (q_head),
      .count (q_cnt)
   );

   // Outstanding-request count and number of pre-flush responses still to discard.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outst_cnt <= '0;
         drop_cnt  <= '0;
      end else begin
         if (grant && !rsp)      outst_cnt <= outst_cnt + OCW'(1);
         else if (rsp && !grant) outst_cnt <= outst_cnt - OCW'(1);

         if (flush)                        drop_cnt <= outst_cnt - (rsp ? OCW'(1) : OCW'(0));
         else if (rsp && drop_cnt != '0)   drop_cnt <= drop_cnt - OCW'(1);
      end
   end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: a PC register and an in-order memory drive the
// fetch stage; a queue-level reference model predicts every output each cycle.
module tb_instr_fetch_queue;
   import riscv_pkg::*;

   localparam int DEPTH     = 4;
   localparam int MAX_OUTST = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] current_PC = RESET_PC;
   logic        flush = 1'b0;
   logic        pc_advance;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        imem_err = 1'b0;
   logic        dec_valid;
   logic        dec_ready = 1'b0;
   logic [31:0] dec_instr;
   logic [31:0] dec_pc;
   logic        dec_err;

   instr_fetch_queue #(.DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .current_PC  (current_PC),
      .flush       (flush),
      .pc_advance  (pc_advance),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .imem_err    (imem_err),
      .dec_valid   (dec_valid),
      .dec_ready   (dec_ready),
      .dec_instr   (dec_instr),
      .dec_pc      (dec_pc),
      .dec_err     (dec_err)
   );

   // Clock
   always #5 clk = ~clk;

   // Stimulus knobs
   int          gnt_pct = 100;
   int          rsp_pct = 100;
   logic        ready_i = 1'b1;
   logic        flush_i = 1'b0;
   logic [31:0] flush_target = '0;
   logic [31:0] err_addr = '0;
   logic        err_rand = 1'b0;
   logic        junk_rsp = 1'b0;
   logic        mem_used = 1'b0;

   // Environment: PC register and memory in-flight list
   logic [31:0] pc_reg = RESET_PC;
   logic [31:0] mem_q[$];

   // Reference model: decode queue {err,pc,instr} and in-flight {stale,pc}
   logic [64:0] exp_q[$];
   logic [32:0] pend_q[$];

   // Observations for directed checks
   logic [32:0] dlog[$];
   int          cyc = 0;
   int          n_grant = 0;
   int          first_grant = -1;
   int          first_valid = -1;
   logic        last_req = 1'b0;

   int n_chk = 0;
   int n_pass = 0;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   function automatic logic err_of(input logic [31:0] a);
      return err_rand ? (a[4:2] == 3'b111) : (a == err_addr);
   endfunction

   task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
      n_chk++;
      if (act !== exp)
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      else
         n_pass++;
   endtask

   // Compare outputs with the model, then advance model and environment.
   task automatic sample();
      logic        req_exp;
      logic        dv_exp;
      logic [32:0] p;
      if (!rst_n) begin
         check("rst_imem_req", imem_req, 1'b0);
         check("rst_pc_advance", pc_advance, 1'b0);
         check("rst_dec_valid", dec_valid, 1'b0);
         check("rst_dec_instr", dec_instr, NOP_INSTR);
         check("rst_dec_pc", dec_pc, RESET_PC);
         check("rst_dec_err", dec_err, 1'b0);
         exp_q.delete();
         pend_q.delete();
         mem_q.delete();
         pc_reg = RESET_PC;
      end else begin
         req_exp = !flush && (exp_q.size() + pend_q.size() < DEPTH) && (pend_q.size() < MAX_OUTST);
         check("imem_req", imem_req, req_exp);
         check("pc_advance", pc_advance, req_exp && imem_gnt);
         if (req_exp) check("imem_addr", imem_addr, current_PC);
         dv_exp = (exp_q.size() != 0) && !flush;
         check("dec_valid", dec_valid, dv_exp);
         if (dv_exp) check("dec_entry", {dec_err, dec_pc, dec_instr}, exp_q[0]);

         if (dv_exp && dec_ready) void'(exp_q.pop_front());
         if (imem_rvalid && pend_q.size() != 0) begin
            p = pend_q.pop_front();
            if (!p[32] && !flush) exp_q.push_back({err_of(p[31:0]), p[31:0], word_of(p[31:0])});
         end
         if (flush) begin
            exp_q.delete();
            foreach (pend_q[i]) pend_q[i][32] = 1'b1;
         end
         if (req_exp && imem_gnt) pend_q.push_back({1'b0, current_PC});

         if (mem_used) void'(mem_q.pop_front());
         if (imem_req && imem_gnt) begin
            mem_q.push_back(imem_addr);
            n_grant++;
            if (first_grant < 0) first_grant = cyc;
         end
         if (dec_valid && first_valid < 0) first_valid = cyc;
         if (dec_valid && dec_ready) dlog.push_back({dec_err, dec_pc});
         if (flush) pc_reg = flush_target;
         else if (imem_req && imem_gnt) pc_reg = pc_reg + 32'd4;
      end
      last_req = imem_req;
   endtask

   // Driver: one clock cycle. Starts just after posedge, samples on negedge.
   task automatic step();
      mem_used = 1'b0;
      imem_gnt = ($urandom_range(99) < gnt_pct);
      if (junk_rsp) begin
         imem_rvalid = 1'b1;
         imem_rdata  = $urandom;
         imem_err    = 1'b0;
      end else if (mem_q.size() != 0 && $urandom_range(99) < rsp_pct) begin
         imem_rvalid = 1'b1;
         imem_rdata  = word_of(mem_q[0]);
         imem_err    = err_of(mem_q[0]);
         mem_used    = 1'b1;
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
         imem_err    = 1'($urandom_range(1));
      end
      flush      = flush_i;
      dec_ready  = ready_i;
      current_PC = pc_reg;
      @(negedge clk);
      sample();
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic begin_test();
      dlog.delete();
      n_grant     = 0;
      first_grant = -1;
      first_valid = -1;
      cyc         = 0;
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      flush_i = 1'b0;
      gnt_pct = 100;
      rsp_pct = 100;
      ready_i = 1'b1;
      repeat (2) step();
      rst_n = 1'b1;
      begin_test();
   endtask

   initial begin
      logic [31:0] tgt;
      @(posedge clk);
      #1;

      // 1: zero-wait streaming
      do_reset();
      repeat (12) step();
      check("t1_first_grant", first_grant, 0);
      check("t1_grant_to_valid", first_valid - first_grant, 2);
      check("t1_count", dlog.size(), 10);
      for (int i = 0; i < 4; i++) check("t1_pc", dlog[i], {1'b0, RESET_PC + 32'(4 * i)});

      // 2: decode stalled, credit stops at DEPTH
      do_reset();
      ready_i = 1'b0;
      repeat (10) step();
      check("t2_grants", n_grant, 4);
      check("t2_req_low", last_req, 1'b0);
      ready_i = 1'b1;
      dlog.delete();
      repeat (8) step();
      for (int i = 0; i < 4; i++) check("t2_order", dlog[i], {1'b0, RESET_PC + 32'(4 * i)});

      // 3: flush with two in flight, responses after flush
      do_reset();
      rsp_pct = 0;
      repeat (3) step();
      check("t3_grants", n_grant, 2);
      flush_i = 1'b1;
      flush_target = 32'h8000_0100;
      step();
      flush_i = 1'b0;
      rsp_pct = 100;
      dlog.delete();
      repeat (12) step();
      check("t3_first", dlog[0], {1'b0, 32'h8000_0100});
      check("t3_second", dlog[1], {1'b0, 32'h8000_0104});

      // 4: flush coinciding with a response
      do_reset();
      rsp_pct = 0;
      repeat (3) step();
      flush_i = 1'b1;
      flush_target = 32'h8000_0200;
      rsp_pct = 100;
      step();
      flush_i = 1'b0;
      dlog.delete();
      repeat (12) step();
      check("t4_first", dlog[0], {1'b0, 32'h8000_0200});
      check("t4_second", dlog[1], {1'b0, 32'h8000_0204});

      // 5: bus error on one word
      do_reset();
      err_addr = 32'h8000_0008;
      repeat (10) step();
      check("t5_before", dlog[1], {1'b0, 32'h8000_0004});
      check("t5_err", dlog[2], {1'b1, 32'h8000_0008});
      check("t5_after", dlog[3], {1'b0, 32'h8000_000C});
      err_addr = '0;

      // 6: reset mid-stream, stale response after release
      do_reset();
      ready_i = 1'b0;
      repeat (3) step();
      rsp_pct = 0;
      step();
      rst_n = 1'b0;
      repeat (2) step();
      rst_n    = 1'b1;
      junk_rsp = 1'b1;
      rsp_pct  = 100;
      ready_i  = 1'b1;
      begin_test();
      step();
      junk_rsp = 1'b0;
      repeat (8) step();
      check("t6_first_grant", first_grant, 0);
      check("t6_restart", dlog[0], {1'b0, RESET_PC});

      // Random traffic with flushes and occasional resets
      err_rand = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         if (n % 200 == 0) begin
            gnt_pct = 40 + $urandom_range(60);
            rsp_pct = 20 + $urandom_range(80);
         end
         ready_i = ($urandom_range(99) < 70);
         flush_i = ($urandom_range(99) < 3);
         tgt = $urandom;
         flush_target = {tgt[31:2], 2'b00};
         rst_n = !($urandom_range(999) < 2);
         step();
      end
      rst_n = 1'b1;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
